// File: rtl/serial_add_pkg.sv
// Shared encodings and defaults for the bit-serial adder/subtractor.
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    // 2'd3 is unused; the controller steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and serial_add_ctrl (slave).
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder, reused once per bit by the controller.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell walked over WIDTH bits, LSB first.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MSB  = CNT_W'(WIDTH - 2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic               r_cmsb;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;
    logic               w_s;
    logic               w_co;

    fa_cell u_fa (
        .x  (r_opa[0]),
        .y  (r_opb[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (r_cnt == CNT_LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand load, serial shift and result capture. Subtraction is a + ~b + 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_cmsb  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_opa   <= bus.a;
                        r_opb   <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_MSB) r_cmsb <= w_co;
                    if (r_cnt == CNT_LAST) begin
                        r_sum  <= {w_s, r_res[WIDTH-1:1]};
                        r_cout <= w_co;
                        r_ovf  <= r_cmsb ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse, registered one cycle after the DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= (r_state == DONE);
    end

    assign bus.busy = (r_state == RUN) || (r_state == DONE);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse, scramble operands afterwards, poke start mid-run,
    // and report when done rose, how long busy was seen and the mid-run sum.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s,
                         output int done_at, output int busy_cnt,
                         output logic [W-1:0] sum_mid);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = s; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = ~a; bus.b = a ^ b; bus.cin = ~ci; bus.sub = ~s;
        done_at  = -1;
        busy_cnt = bus.busy ? 1 : 0;
        sum_mid  = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_cnt++;
            if (i == 3) bus.start = 1'b1;
            if (i == 4) begin bus.start = 1'b0; sum_mid = bus.sum; end
            if (bus.done) begin done_at = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                         i, bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
            end
        end
    endtask

    task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic s, input logic [W-1:0] prev_sum,
                           input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int done_at, busy_cnt;
        logic [W-1:0] sum_mid;
        do_op(a, b, ci, s, done_at, busy_cnt, sum_mid);
        n_checks++;
        if (done_at !== W + 1) begin
            n_fail++; $display("FAIL %s latency: done after %0d edges, want %0d", name, done_at, W + 1);
        end
        n_checks++;
        if (busy_cnt !== W + 1) begin
            n_fail++; $display("FAIL %s busy_len: %0d cycles, want %0d", name, busy_cnt, W + 1);
        end
        n_checks++;
        if (sum_mid !== prev_sum) begin
            n_fail++; $display("FAIL %s sum_hold: sum=%h mid-run, want %h", name, sum_mid, prev_sum);
        end
        n_checks++;
        if ({bus.sum, bus.cout, bus.ovf} !== {e_sum, e_cout, e_ovf}) begin
            n_fail++;
            $display("FAIL %s result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, bus.sum, bus.cout, bus.ovf, e_sum, e_cout, e_ovf);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s pulse_end: done=%b busy=%b, want 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_add();
        test_op("add_5a_3c",   8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h96, 1'b0, 1'b1);
        test_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0);
        test_op("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        test_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'h01, 8'hF0, 1'b0, 1'b0);
        test_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'hF0, 8'h7F, 1'b1, 1'b1);
    endtask

    // start held high; operands only valid on the sampling edges (every W+2).
    task automatic test_back_to_back();
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        logic         oc [3];
        logic         os [3];
        logic [W-1:0] es [3];
        logic         ec [3];
        logic         eo [3];
        int           n_done;
        oa = '{8'h12, 8'h05, 8'h7F}; ob = '{8'h34, 8'h07, 8'h01};
        oc = '{1'b1, 1'b0, 1'b0};    os = '{1'b0, 1'b1, 1'b0};
        es = '{8'h47, 8'hFE, 8'h80}; ec = '{1'b0, 1'b0, 1'b0}; eo = '{1'b0, 1'b0, 1'b1};
        n_done = 0;
        for (int c = 0; c < 3 * (W + 2); c++) begin
            @(negedge clk);
            bus.start = 1'b1;
            if (c % (W + 2) == 0) begin
                bus.a = oa[c / (W + 2)]; bus.b = ob[c / (W + 2)];
                bus.cin = oc[c / (W + 2)]; bus.sub = os[c / (W + 2)];
            end else begin
                bus.a = W'(c * 37); bus.b = W'(c * 11 + 3); bus.cin = c[0]; bus.sub = c[1];
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.done !== (c % (W + 2) == W + 1)) begin
                n_fail++; $display("FAIL b2b_done edge%0d: done=%b, want %b", c, bus.done, (c % (W + 2) == W + 1));
            end
            if (bus.done) begin
                n_checks++;
                if ({bus.sum, bus.cout, bus.ovf} !== {es[n_done], ec[n_done], eo[n_done]}) begin
                    n_fail++;
                    $display("FAIL b2b_result op%0d: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             n_done, bus.sum, bus.cout, bus.ovf, es[n_done], ec[n_done], eo[n_done]);
                end
                if (n_done < 2) n_done++;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n_done;
        int done_at, busy_cnt;
        logic [W-1:0] sum_mid;
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        n_done = 0;
        repeat (2) begin @(negedge clk); if (bus.done) n_done++; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (bus.done || bus.busy) n_done++; end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++; $display("FAIL abort_no_done: %0d done/busy samples, want 0", n_done);
        end
        do_op(8'h01, 8'h02, 1'b0, 1'b0, done_at, busy_cnt, sum_mid);
        n_checks++;
        if (done_at !== W + 1 || {bus.sum, bus.cout, bus.ovf} !== {8'h03, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_recover: done_at=%0d sum=%h cout=%b ovf=%b, want %0d 03 0 0",
                     done_at, bus.sum, bus.cout, bus.ovf, W + 1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
